// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int NREQ     = 4;
    localparam int REQ_DMA  = 0;
    localparam int REQ_TAPE = 1;
    localparam int REQ_FDD  = 2;
    localparam int REQ_CPU  = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_ACK
    } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_pick.sv
// Combinational winner selection: lowest request index wins unless the CPU
// has waited long enough, in which case it jumps to the front.
module arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            starve,
    output logic [1:0]      idx,
    output logic            valid
);

    // Fixed priority with CPU starvation override.
    always_comb begin
        idx   = 2'(REQ_DMA);
        valid = |req;
        if (req[REQ_CPU] && starve) begin
            idx = 2'(REQ_CPU);
        end else if (req[REQ_DMA]) begin
            idx = 2'(REQ_DMA);
        end else if (req[REQ_TAPE]) begin
            idx = 2'(REQ_TAPE);
        end else if (req[REQ_FDD]) begin
            idx = 2'(REQ_FDD);
        end else if (req[REQ_CPU]) begin
            idx = 2'(REQ_CPU);
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the single-byte SDRAM controller port between DMA, tape, FDD and
// CPU requesters with a req/ack handshake.
// Handshake: a requester raises req[i] with we/addr/din stable and holds them
// until ack[i] pulses for one cycle; the grant is frozen from IDLE until ACK.
// Controller side: one-cycle mem_rd/mem_we strobe in ISSUE, then wait for a
// one-cycle mem_done (or the watchdog) in WAIT.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = 25,
    parameter int STARVE_LIMIT = 15,
    parameter int TIMEOUT      = 255
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*8-1:0]      din,
    output logic [NREQ-1:0]        ack,
    output logic [7:0]             dout,
    output logic                   err,
    output logic                   busy,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [7:0]             mem_din,
    output logic                   mem_we,
    output logic                   mem_rd,
    input  logic [7:0]             mem_dout,
    input  logic                   mem_done,
    input  logic                   mem_ready,
    output arb_state_e             dbg_state
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    arb_state_e      state, state_nx;
    logic [1:0]      grant;
    logic            we_lat;
    logic            err_flag;
    logic [SW-1:0]   starve_cnt;
    logic [WW-1:0]   wd;
    logic [1:0]      pick_idx;
    logic            pick_valid;
    logic            starve;
    logic            fire;
    logic            wd_hit;

    assign starve    = (starve_cnt >= SW'(STARVE_LIMIT));
    assign fire      = (state == ARB_IDLE) && pick_valid && mem_ready;
    // wd is 0 in the first WAIT cycle, so hitting TIMEOUT-2 lands ACK exactly
    // TIMEOUT cycles after ISSUE. A simultaneous mem_done wins.
    assign wd_hit    = (state == ARB_WAIT) && !mem_done && (wd == WW'(TIMEOUT - 2));
    assign dbg_state = state;

    arb_pick u_pick (
        .req   (req),
        .starve(starve),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_nx;
    end

    // Next state and strobe/ack decode.
    always_comb begin
        state_nx = state;
        ack      = '0;
        err      = 1'b0;
        mem_we   = 1'b0;
        mem_rd   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (fire) state_nx = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                mem_we   = we_lat;
                mem_rd   = !we_lat;
                state_nx = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_done || wd_hit) state_nx = ARB_ACK;
            end
            ARB_ACK: begin
                ack      = NREQ'(1) << grant;
                err      = err_flag;
                state_nx = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    // Grant latch, controller-side registers, read data and watchdog.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            grant    <= '0;
            we_lat   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            dout     <= '0;
            busy     <= 1'b0;
            err_flag <= 1'b0;
            wd       <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (fire) begin
                        grant    <= pick_idx;
                        we_lat   <= we[pick_idx];
                        mem_addr <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        mem_din  <= din[int'(pick_idx)*8 +: 8];
                        busy     <= 1'b1;
                        err_flag <= 1'b0;
                    end
                end
                ARB_ISSUE: begin
                    wd <= '0;
                end
                ARB_WAIT: begin
                    wd <= wd + 1'b1;
                    if (mem_done && !we_lat) dout <= mem_dout;
                    if (wd_hit) err_flag <= 1'b1;
                end
                ARB_ACK: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // CPU starvation counter: counts cycles the CPU waits while others own the port.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!req[REQ_CPU]) begin
            starve_cnt <= '0;
        end else if ((fire && pick_idx == 2'(REQ_CPU)) || (busy && grant == 2'(REQ_CPU))) begin
            starve_cnt <= '0;
        end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
